// File: rtl/prescale_sequencer.sv
// -----------------------------------------------------------------------------
// prescale_sequencer
//
// Controller for a cascaded 3-digit BCD prescaler used for 1 Hz tick
// generation. It owns the prescaler digits and sequences them under
// start/stop/clear commands. The terminal count is programmable in BCD. The
// block emits a programmed number of ticks and then signals done.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   start      in   start/resume command
//   stop       in   pause command
//   clear      in   abort command, returns to IDLE
//   tc_bcd     in   terminal count, BCD {d2,d1,d0}
//   tick_load  in   number of ticks to generate
//   tick       out  one-cycle pulse on each prescaler wrap (registered)
//   c_enable   out  per-digit count enables {d2_en,d1_en,d0_en}
//   digits     out  current prescaler value, BCD {d2,d1,d0}
//   ticks_left out  ticks remaining
//   busy       out  high in RUN or PAUSE
//   done       out  one-cycle pulse when the final tick is issued (registered)
//
// Command priority is clear > stop > start. An asserted stop masks start in
// every state, so start+stop together never starts or resumes.
//
// Build option:
//   AUTO_RELOAD_EN  when defined, the final tick reloads ticks_left from the
//                   latched load value and the sequencer stays in RUN.
// -----------------------------------------------------------------------------
module prescale_sequencer #(
  parameter int TICKS_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic [11:0]        tc_bcd,
  input  logic [TICKS_W-1:0] tick_load,
  output logic               tick,
  output logic [2:0]         c_enable,
  output logic [11:0]        digits,
  output logic [TICKS_W-1:0] ticks_left,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [11:0]        digits_d;
  logic [11:0]        tc_q;
  logic [11:0]        tc_d;
  logic [TICKS_W-1:0] ticks_left_d;
  logic               tick_d;
  logic               done_d;
`ifdef AUTO_RELOAD_EN
  logic [TICKS_W-1:0] load_q;
  logic [TICKS_W-1:0] load_d;
`endif

  // Out-of-range BCD digits are clamped so the prescaler can always reach tc.
  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  logic        go;
  logic        d0_nine;
  logic        d1_nine;
  logic        d2_nine;
  logic        at_tc;
  logic        last_tick;
  logic [11:0] digits_inc;

  assign go        = start & ~stop;
  assign d0_nine   = (digits[3:0]  == 4'd9);
  assign d1_nine   = (digits[7:4]  == 4'd9);
  assign d2_nine   = (digits[11:8] == 4'd9);
  assign at_tc     = (digits == tc_q);
  assign last_tick = (ticks_left <= TICKS_W'(1));

  // BCD ripple increment: each digit carries 9->0 into the next one.
  always_comb begin
    digits_inc[3:0]  = d0_nine ? 4'd0 : digits[3:0] + 4'd1;
    digits_inc[7:4]  = digits[7:4];
    digits_inc[11:8] = digits[11:8];
    if (d0_nine) begin
      digits_inc[7:4] = d1_nine ? 4'd0 : digits[7:4] + 4'd1;
    end
    if (d0_nine && d1_nine) begin
      digits_inc[11:8] = d2_nine ? 4'd0 : digits[11:8] + 4'd1;
    end
  end

  // Next-state and datapath decisions.
  always_comb begin
    state_d      = state_q;
    digits_d     = digits;
    ticks_left_d = ticks_left;
    tc_d         = tc_q;
    tick_d       = 1'b0;
    done_d       = 1'b0;
`ifdef AUTO_RELOAD_EN
    load_d       = load_q;
`endif
    if (clear) begin
      state_d      = S_IDLE;
      digits_d     = 12'h000;
      ticks_left_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (go) begin
            if (tick_load != '0) begin
              state_d      = S_RUN;
              digits_d     = 12'h000;
              ticks_left_d = tick_load;
              tc_d         = {clamp9(tc_bcd[11:8]), clamp9(tc_bcd[7:4]),
                              clamp9(tc_bcd[3:0])};
`ifdef AUTO_RELOAD_EN
              load_d       = tick_load;
`endif
            end else begin
              // Zero-length run: report completion without ever ticking.
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        S_RUN: begin
          if (stop) begin
            // Pausing edge does not advance, so a due wrap is deferred.
            state_d = S_PAUSE;
          end else if (at_tc) begin
            digits_d = 12'h000;
            tick_d   = 1'b1;
            if (last_tick) begin
              done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
              ticks_left_d = load_q;
`else
              ticks_left_d = '0;
              state_d      = S_DONE;
`endif
            end else begin
              ticks_left_d = ticks_left - TICKS_W'(1);
            end
          end else begin
            digits_d = digits_inc;
          end
        end
        S_PAUSE: begin
          if (go) begin
            state_d = S_RUN;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits     <= 12'h000;
      ticks_left <= '0;
      tc_q       <= 12'h000;
      tick       <= 1'b0;
      done       <= 1'b0;
    end else begin
      digits     <= digits_d;
      ticks_left <= ticks_left_d;
      tc_q       <= tc_d;
      tick       <= tick_d;
      done       <= done_d;
    end
  end

`ifdef AUTO_RELOAD_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q <= '0;
    end else begin
      load_q <= load_d;
    end
  end
`endif

  assign busy     = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign c_enable = (state_q == S_RUN) ? {d1_nine & d0_nine, d0_nine, 1'b1}
                                       : 3'b000;

endmodule

// File: tb/tb_prescale_sequencer.sv
// -----------------------------------------------------------------------------
// tb_prescale_sequencer
//
// Bench for prescale_sequencer. An integer-level reference model (phase
// counter, tick budget, mode) predicts every output each cycle; directed
// scenarios pin the model with hand-computed tick timings.
// -----------------------------------------------------------------------------
module tb_prescale_sequencer;

  localparam int TICKS_W = 8;
  localparam int W = 1 + 3 + 12 + TICKS_W + 1 + 1;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic               clk;
  logic               reset;
  logic               start;
  logic               stop;
  logic               clear;
  logic [11:0]        tc_bcd;
  logic [TICKS_W-1:0] tick_load;
  logic               tick;
  logic [2:0]         c_enable;
  logic [11:0]        digits;
  logic [TICKS_W-1:0] ticks_left;
  logic               busy;
  logic               done;

  int checks_total  = 0;
  int checks_passed = 0;

  prescale_sequencer #(.TICKS_W(TICKS_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .tc_bcd     (tc_bcd),
    .tick_load  (tick_load),
    .tick       (tick),
    .c_enable   (c_enable),
    .digits     (digits),
    .ticks_left (ticks_left),
    .busy       (busy),
    .done       (done)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ------------------------------------------------------- reference model
  int   m_mode, m_cnt, m_left, m_tc, m_load;
  logic m_tick, m_done;
  logic [W-1:0] exp_q[$];

  function automatic int dig(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  task automatic model_step();
    m_tick = 1'b0;
    m_done = 1'b0;
    if (reset) begin
      m_mode = M_IDLE; m_cnt = 0; m_left = 0; m_tc = 0; m_load = 0;
    end else if (clear) begin
      m_mode = M_IDLE; m_cnt = 0; m_left = 0;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE: begin
          if (start && !stop) begin
            if (tick_load != 0) begin
              m_mode = M_RUN;
              m_cnt  = 0;
              m_tc   = dig(tc_bcd[11:8]) * 100 + dig(tc_bcd[7:4]) * 10 + dig(tc_bcd[3:0]);
              m_load = int'(tick_load);
              m_left = int'(tick_load);
            end else begin
              m_done = 1'b1;
              m_mode = M_IDLE;
            end
          end
        end
        M_RUN: begin
          if (stop) m_mode = M_PAUSE;
          else if (m_cnt == m_tc) begin
            m_cnt  = 0;
            m_tick = 1'b1;
            if (m_left == 1) begin
              m_done = 1'b1;
`ifdef AUTO_RELOAD_EN
              m_left = m_load;
`else
              m_left = 0;
              m_mode = M_DONE;
`endif
            end else m_left = m_left - 1;
          end else m_cnt = m_cnt + 1;
        end
        default: begin
          if (start && !stop) m_mode = M_RUN;
        end
      endcase
    end
  endtask

  function automatic logic [W-1:0] model_out();
    logic [11:0] d;
    logic [2:0]  en;
    d  = {4'(m_cnt / 100), 4'((m_cnt / 10) % 10), 4'(m_cnt % 10)};
    en = (m_mode == M_RUN) ? {(m_cnt % 100) == 99, (m_cnt % 10) == 9, 1'b1} : 3'b000;
    return {m_tick, en, d, TICKS_W'(m_left),
            (m_mode == M_RUN) || (m_mode == M_PAUSE), m_done};
  endfunction

  // Every-cycle scoreboard: model advances on the edge, DUT sampled 1 ns later.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      model_step();
      exp_q.push_back(model_out());
      #1;
      e = exp_q.pop_front();
      check("tick",       tick,       e[W-1]);
      check("c_enable",   c_enable,   e[W-2 -: 3]);
      check("digits",     digits,     e[W-5 -: 12]);
      check("ticks_left", ticks_left, e[TICKS_W+1 -: TICKS_W]);
      check("busy",       busy,       e[1]);
      check("done",       done,       e[0]);
    end
  end

  // ------------------------------------------------------------- drivers
  task automatic pulse_start(input logic [11:0] tc, input logic [TICKS_W-1:0] ld,
                             output logic s_tick, output logic s_done,
                             output logic s_busy);
    @(negedge clk);
    tc_bcd = tc; tick_load = ld; start = 1'b1;
    @(posedge clk);
    #1;
    s_tick = tick; s_done = done; s_busy = busy;
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs to show they are only sampled on the starting edge.
    tc_bcd = 12'($urandom); tick_load = TICKS_W'($urandom);
  endtask

  task automatic wait_tick(input int budget, output int n, output logic s_done,
                           output logic [TICKS_W-1:0] s_left, output logic s_busy);
    n = 0; s_done = 1'b0; s_left = '0; s_busy = 1'b0;
    while (n < budget) begin
      @(posedge clk);
      #1;
      n++;
      if (tick) begin
        s_done = done; s_left = ticks_left; s_busy = busy;
        return;
      end
    end
    checks_total++;
    $display("FAIL tick_timeout: no tick within %0d edges (required a tick)", budget);
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    logic               st, sd, sb;
    logic [TICKS_W-1:0] sl;
    int                 n;

    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    tc_bcd = 12'h000; tick_load = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {tick, c_enable, digits, ticks_left, busy, done}, 0);
    reset = 1'b0;

    // tc=999, two ticks a thousand edges apart.
    pulse_start(12'h999, 8'd2, st, sd, sb);
    check("t1_busy_after_start", sb, 1);
    wait_tick(1100, n, sd, sl, sb);
    check("t1_first_tick_edges", n, 1000);
    check("t1_first_left", sl, 1);
    check("t1_first_no_done", sd, 0);
    wait_tick(1100, n, sd, sl, sb);
    check("t1_second_tick_edges", n, 1000);
    check("t1_done_with_tick", sd, 1);
    check("t1_left_zero", sl, 0);
    check("t1_busy_low", sb, 0);

    // tc=005, three ticks six edges apart.
    pulse_start(12'h005, 8'd3, st, sd, sb);
    for (int i = 0; i < 3; i++) begin
      wait_tick(20, n, sd, sl, sb);
      check("t2_period", n, 6);
      check("t2_left", sl, 2 - i);
      check("t2_done", sd, (i == 2) ? 1 : 0);
    end

    // tc=000: tick and done on the first edge; load=0 gives a bare done.
    pulse_start(12'h000, 8'd1, st, sd, sb);
    wait_tick(5, n, sd, sl, sb);
    check("t4_tick_edges", n, 1);
    check("t4_done", sd, 1);
    pulse_start(12'h005, 8'd0, st, sd, sb);
    check("t4_zero_done", sd, 1);
    check("t4_zero_no_tick", st, 0);
    check("t4_zero_not_busy", sb, 0);

    // Out-of-range digits clamp to 909.
    pulse_start(12'hA0F, 8'd1, st, sd, sb);
    wait_tick(1000, n, sd, sl, sb);
    check("t5_clamped_edges", n, 910);

    // Pause after three advancing edges, hold, resume.
    pulse_start(12'h999, 8'd1, st, sd, sb);
    repeat (3) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (10) @(negedge clk);
    check("t3_paused_digits", digits, 12'h003);
    check("t3_paused_busy", busy, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_tick(1100, n, sd, sl, sb);
    check("t3_resume_edges", n, 997);
    check("t3_done", sd, 1);

    // clear with start+stop on the edge where a wrap would be due.
    pulse_start(12'h005, 8'd3, st, sd, sb);
    repeat (5) @(negedge clk);
    clear = 1'b1; start = 1'b1; stop = 1'b1;
    @(posedge clk);
    #1;
    check("t6_clear_no_tick", tick, 0);
    check("t6_clear_idle", {busy, digits, ticks_left}, 0);
    @(negedge clk);
    clear = 1'b0; start = 1'b0; stop = 1'b0;

    // Asynchronous reset mid-run.
    pulse_start(12'h999, 8'd5, st, sd, sb);
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("t6_async_reset", {tick, c_enable, digits, ticks_left, busy, done}, 0);
    @(negedge clk);
    reset = 1'b0;

`ifdef AUTO_RELOAD_EN
    pulse_start(12'h003, 8'd2, st, sd, sb);
    wait_tick(10, n, sd, sl, sb);
    check("ar_first_edges", n, 4);
    wait_tick(10, n, sd, sl, sb);
    check("ar_done", sd, 1);
    check("ar_reload", sl, 2);
    check("ar_busy", sb, 1);
    wait_tick(10, n, sd, sl, sb);
    check("ar_continue_edges", n, 4);
    check("ar_continue_left", sl, 1);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
`endif

    // Randomized commands, checked cycle by cycle by the scoreboard.
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 99) < 15);
      stop  = ($urandom_range(0, 99) < 4);
      clear = ($urandom_range(0, 99) < 2);
      reset = ($urandom_range(0, 999) < 3);
      if ($urandom_range(0, 7) == 0) tc_bcd = 12'($urandom);
      else tc_bcd = {4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
      tick_load = TICKS_W'($urandom_range(0, 4));
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clear = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/prescale_sequencer.md
Name: prescale_sequencer

Overview:
Controller for the cascaded 3-digit BCD prescaler used for 1 Hz tick generation. It owns the prescaler digits and sequences them under start/stop/clear commands. The terminal count is programmable in BCD. It emits a fixed number of ticks, then signals done. It sits between the timing-control logic and the downstream tick consumers.

Parameters:
TICKS_W, 8, width of the tick-count load value and the remaining-ticks counter.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  start/resume command, sampled each edge
stop  in  1  pause command
clear  in  1  abort command; returns the block to IDLE
tc_bcd  in  12  terminal count as 3 BCD digits {d2,d1,d0}
tick_load  in  TICKS_W  number of ticks to generate
tick  out  1  one-cycle pulse on each prescaler wrap
c_enable  out  3  per-digit count enables {d2_en,d1_en,d0_en}
digits  out  12  current prescaler value, BCD {d2,d1,d0}
ticks_left  out  TICKS_W  ticks remaining
busy  out  1  high in RUN or PAUSE
done  out  1  one-cycle pulse when the final tick is issued

Behaviour:
- Single clock domain. Reset is asynchronous and active-high.
- While reset is asserted: state=IDLE; digits=000; ticks_left=0; tick=0; done=0; busy=0; c_enable=000; latched tc=000; latched load=0.
- States: IDLE, RUN, PAUSE, DONE, in a one-hot or encoded FSM.
- Command priority: clear > stop > start.
- clear, in any state: next edge goes to IDLE, digits=000, ticks_left=0. No tick or done is issued.
- IDLE or DONE, start with tick_load!=0:
  - go to RUN and set digits=000.
  - latch tc_bcd into tc_q and tick_load into load_q.
  - set ticks_left=tick_load.
- IDLE or DONE, start with tick_load==0: done pulses one cycle; state becomes IDLE.
- Latching rule: any tc_bcd digit >9 is clamped to 9 when latched.
- tc_bcd and tick_load are sampled only on the start that enters RUN. Changes to them in RUN or PAUSE have no effect.
- RUN, no stop and no clear: the prescaler advances once per edge.
  - digits!=tc_q: d0 increments. d1 increments when d0==9. d2 increments when d1==9 and d0==9. Digits carry 9->0.
  - digits==tc_q: digits go to 000, tick=1 for that cycle, ticks_left decrements.
  - Tick period is value(tc_q)+1 cycles. The first tick is registered tc+1 edges after the start edge.
- Final tick (ticks_left==1 at the wrap): ticks_left->0, tick=1, done=1 in the same cycle; state goes to DONE.
- stop in RUN: go to PAUSE. The prescaler does not advance on that edge, so a wrap due on that edge is deferred.
- PAUSE: digits and ticks_left hold. start resumes RUN with no reload. stop is ignored.
- start in RUN is ignored.
- tick and done are registered and low in every cycle not listed above.
- c_enable outside RUN is 000. In RUN it is {d1==9&d0==9, d0==9, 1}.
- tc_q=000: tick every cycle in RUN.
- DONE: digits=000, busy=0. Leaves only on start or clear.

Optional Feature:
AUTO_RELOAD_EN
- Defined: on the final tick, ticks_left reloads from load_q instead of reaching 0. State stays RUN and done still pulses. Ticks continue until stop or clear.
- Undefined: behaviour as above; the final tick enters DONE.

Test Plan:
1. tc=999, load=2, start at edge k → tick at edges k+1000 and k+2000. done coincides with the second tick, then state DONE, busy=0, ticks_left=0.
2. tc=005, load=3 → digits cycle 000..005 and tick every 6 cycles, 3 ticks total. c_enable stays 001 except d1_en=0 throughout.
3. tc=999, load=1, stop after 3 RUN edges → digits hold 003 for 10 cycles. start resumes; tick at 1000 RUN-active edges after the original start.
4. tc=000, load=1 → tick=1 and done=1 at edge k+1. Start with load=0 → done pulse only, no tick, busy stays 0.
5. tc_bcd=12'hA0F, load=1 → latched tc_q=909; tick after 910 edges.
6. Asynchronous reset mid-RUN → all outputs 0 immediately. A clear asserted together with start/stop → IDLE with no tick. With AUTO_RELOAD_EN, load=2 → ticks_left reloads to 2 on done and ticks continue.
